// File: rtl/div_controller.sv
// div_controller: sequences the shared unsigned divider for RISC-V DIV/DIVU/REM/REMU,
// resolving divide-by-zero and signed overflow locally and fixing result signs.
module div_controller #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             flush,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             cmd_err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_result,
  input  logic [WIDTH-1:0] div_reminder,
  input  logic             div_done,
  input  logic             div_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, SPECIAL, ARM, WAIT, FIX, OUT} state_t;
  state_t state;
  logic rem, sgn, err;
  logic [WIDTH-1:0] a, b, q, r;
  logic [CW-1:0] cnt;
  logic legal, sgn_in, spec;
  logic [WIDTH-1:0] qv, rv, sp;
  always_comb begin
    legal  = op_valid && funct3[2];
    sgn_in = !funct3[0];
    spec   = rs2 == '0 || (sgn_in && rs1 == MIN && rs2 == '1);
    qv     = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -q : q;
    rv     = (sgn && a[WIDTH-1]) ? -r : r;
    sp     = b == '0 ? (rem ? a : '1) : (rem ? '0 : MIN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      result_valid <= 1'b0;
      result <= '0;
      cmd_err <= 1'b0;
      div_start <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      cnt <= '0;
      rem <= 1'b0;
      sgn <= 1'b0;
      err <= 1'b0;
      a <= '0;
      b <= '0;
      q <= '0;
      r <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
      busy <= 1'b0;
      result_valid <= 1'b0;
      div_start <= 1'b0;
    end else begin
      case (state)
        IDLE: if (legal && !flush) begin
          rem <= funct3[1];
          sgn <= sgn_in;
          a <= rs1;
          b <= rs2;
          busy <= 1'b1;
          if (spec) state <= SPECIAL;
          else begin
            div_dividend <= (sgn_in && rs1[WIDTH-1]) ? -rs1 : rs1;
            div_divisor <= (sgn_in && rs2[WIDTH-1]) ? -rs2 : rs2;
            state <= ARM;
          end
        end
        SPECIAL: begin
          result <= sp;
          cmd_err <= 1'b0;
          result_valid <= 1'b1;
          state <= OUT;
        end
        ARM: if (!div_done) begin
          div_start <= 1'b1;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (div_done) begin
          q <= div_result;
          r <= div_reminder;
          err <= div_err;
          div_start <= 1'b0;
          state <= FIX;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cmd_err <= 1'b1;
          result <= '0;
          result_valid <= 1'b1;
          div_start <= 1'b0;
          state <= OUT;
        end else cnt <= cnt + 1'b1;
        FIX: begin
          result <= rem ? rv : qv;
          cmd_err <= err;
          result_valid <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          result_valid <= 1'b0;
          busy <= 1'b0;
          div_start <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_controller.sv
// tb_div_controller: randomized check of div_controller against an arithmetic reference model.
module tb_div_controller;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk = 0, reset = 1, op_valid = 0, flush = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] rs1 = 0, rs2 = 0;
  logic busy, result_valid, cmd_err, div_start;
  logic [31:0] result, div_dividend, div_divisor;
  logic [31:0] div_result = 0, div_reminder = 0;
  logic div_done = 0, div_err = 0;
  int checks = 0, errors = 0, mode = 0, lat = 0, k = 0;
  always #5 clk = ~clk;
  div_controller #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .result_valid(result_valid), .result(result), .cmd_err(cmd_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_result(div_result), .div_reminder(div_reminder), .div_done(div_done), .div_err(div_err)
  );
  // divider stub: mode 0 normal, 1 never done, 2 done with error; done held until start drops
  always @(posedge clk) begin
    if (reset || !div_start) begin
      div_done <= 0;
      div_err <= 0;
      k <= 0;
    end else if (mode != 1 && !div_done) begin
      if (k >= lat) begin
        div_done <= 1;
        div_err <= (mode == 2);
        div_result <= div_divisor == 0 ? '1 : div_dividend / div_divisor;
        div_reminder <= div_divisor == 0 ? div_dividend : div_dividend % div_divisor;
      end else k <= k + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic rm = f[1];
    logic s = !f[0];
    if (y == 0) return rm ? x : 32'hFFFF_FFFF;
    if (s && x == MIN && y == 32'hFFFF_FFFF) return rm ? 32'h0 : MIN;
    if (s) return rm ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
    return rm ? x % y : x / y;
  endfunction
  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? 32'h0 - x : x;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 0;
      1: return MIN;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 20;
      default: return $urandom;
    endcase
  endfunction
  task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                     input int m, input int l, input string tag);
    int n, exp_lat;
    logic saw, bok, spec;
    spec = y == 0 || (!f[0] && x == MIN && y == 32'hFFFF_FFFF);
    exp_lat = spec ? 2 : (m == 1 ? 10 : 5 + l);
    mode = m;
    lat = l;
    @(negedge clk);
    op_valid = 1; funct3 = f; rs1 = x; rs2 = y;
    @(negedge clk);
    op_valid = 0;
    n = 1; saw = 0; bok = 1;
    if (!spec) begin
      chk({tag, ".dividend"}, div_dividend, mag(x, !f[0]));
      chk({tag, ".divisor"}, div_divisor, mag(y, !f[0]));
    end
    while (!result_valid && n < 60) begin
      bok &= busy;
      saw |= div_start;
      @(negedge clk);
      n++;
    end
    bok &= busy;
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".result"}, result, m == 1 ? 32'h0 : ref_res(f, x, y));
    chk({tag, ".cmd_err"}, cmd_err, m != 0);
    chk({tag, ".busy"}, bok, 1);
    if (spec) chk({tag, ".no_start"}, saw, 0);
    @(negedge clk);
    chk({tag, ".busy_off"}, busy, 0);
    chk({tag, ".rv_off"}, result_valid, 0);
  endtask
  initial begin
    logic [31:0] prev;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst.busy", busy, 0);
    chk("rst.rv", result_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.err", cmd_err, 0);
    chk("rst.start", div_start, 0);
    chk("rst.dd", div_dividend, 0);
    chk("rst.dv", div_divisor, 0);
    run(3'b100, 32'hFFFF_FFF9, 2, 0, 1, "div_neg");
    run(3'b110, 32'hFFFF_FFF9, 2, 0, 0, "rem_neg");
    run(3'b101, 32'hFFFF_FFFE, 2, 0, 2, "divu");
    run(3'b111, 12, 5, 0, 3, "remu");
    run(3'b100, 5, 0, 0, 0, "div_by0");
    run(3'b110, 5, 0, 0, 0, "rem_by0");
    run(3'b100, MIN, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    run(3'b110, MIN, 32'hFFFF_FFFF, 0, 0, "rem_ovf");
    run(3'b101, MIN, 32'hFFFF_FFFF, 0, 1, "divu_big");
    // flush in the third WAIT cycle
    prev = result;
    mode = 1;
    @(negedge clk);
    op_valid = 1; funct3 = 3'b100; rs1 = 100; rs2 = 7;
    repeat (4) begin
      @(negedge clk);
      op_valid = 0;
    end
    chk("flush.start_before", div_start, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush.start", div_start, 0);
    chk("flush.busy", busy, 0);
    chk("flush.rv", result_valid, 0);
    chk("flush.result", result, prev);
    run(3'b101, 12, 3, 0, 0, "after_flush");
    // illegal funct3, and op_valid together with flush in IDLE, are not accepted
    @(negedge clk);
    op_valid = 1; funct3 = 3'b001; rs1 = 9; rs2 = 3;
    @(negedge clk);
    chk("illegal.busy", busy, 0);
    funct3 = 3'b100; flush = 1;
    @(negedge clk);
    op_valid = 0; flush = 0;
    chk("flush_idle.busy", busy, 0);
    run(3'b100, 100, 7, 1, 0, "timeout");
    run(3'b100, 100, 7, 2, 1, "div_err");
    run(3'b110, 32'hFFFF_FF9C, 7, 0, 0, "after_err");
    for (int i = 0; i < 40; i++)
      run(3'(4 + $urandom % 4), pick(), pick(), 0, $urandom % 5, "rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_controller.md
Name: div_controller

Overview:
Sequencer for the shared unsigned iterative `divider` in the execute stage. It accepts RISC-V M-extension DIV/DIVU/REM/REMU requests and converts signed operands to magnitudes. It drives the divider's level start/done handshake, resolves the spec-defined special cases (divide-by-zero, signed overflow) without touching the divider, and fixes result signs. While an operation is in flight it holds the pipeline stalled through `busy`.

Parameters:
WIDTH, 32, operand/result width.
TIMEOUT, 64, max cycles to wait for div_done before aborting with cmd_err.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
op_valid  input  1  request; sampled only in IDLE.
funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; others ignored (no accept).
rs1  input  WIDTH  dividend operand.
rs2  input  WIDTH  divisor operand.
flush  input  1  abort the in-flight operation.
busy  output  1  high from cycle after accept until the cycle after result_valid; stall request.
result_valid  output  1  one-cycle pulse, result is valid.
result  output  WIDTH  final quotient/remainder; held until next result_valid.
cmd_err  output  1  valid with result_valid; high on timeout or divider err.
div_start  output  1  level start to divider.
div_dividend  output  WIDTH  magnitude of dividend (registered).
div_divisor  output  WIDTH  magnitude of divisor (registered).
div_result  input  WIDTH  unsigned quotient.
div_reminder  input  WIDTH  unsigned remainder.
div_done  input  1  divider completion.
div_err  input  1  divider error.

Behaviour:
- Reset: state IDLE; busy, result_valid, cmd_err, div_start = 0; result, div_dividend, div_divisor, timeout counter = 0.
- States: IDLE, SPECIAL, ARM, WAIT, FIX, OUT.
- IDLE: on op_valid with a legal funct3, latch funct3, rs1, rs2 and the signed flag (funct3[0]==0).
  - If rs2==0 or signed overflow (rs1==0x80000000 and rs2==0xFFFFFFFF), go to SPECIAL.
  - Otherwise load magnitudes into div_dividend/div_divisor (abs() if signed, raw if unsigned) and go to ARM.
- SPECIAL (1 cycle): compute the result, then go to OUT. div_start is never asserted.
  - Divide-by-zero: quotient = all ones; remainder = rs1.
  - Overflow: quotient = 0x80000000; remainder = 0.
- ARM: wait until div_done==0, which protects against a stale done from the previous op. Then assert div_start, clear the timeout counter and go to WAIT.
- WAIT: hold div_start=1 and increment the counter each cycle.
  - div_done=1: capture div_result/div_reminder and div_err, then go to FIX.
  - Counter reaches TIMEOUT-1 without done: set cmd_err, set result=0 and go to OUT.
- FIX (1 cycle): deassert div_start. Apply sign rules, then go to OUT.
  - Quotient is negated (two's complement) iff signed and sign(rs1)!=sign(rs2).
  - Remainder is negated iff signed and rs1<0.
  - Select quotient for funct3[1]==0, remainder otherwise.
  - cmd_err = captured div_err.
- OUT: result_valid=1 for exactly this cycle, div_start=0, then go to IDLE.
- busy is registered: it rises the cycle after accept and falls the cycle after OUT. A new op can be accepted the cycle after OUT.
- Latency:
  - Special cases: result_valid 2 cycles after accept.
  - Normal ops: accept + 1 (ARM) + divider cycles + FIX + OUT.
- flush has priority over everything except reset. In any non-IDLE state it returns to IDLE next cycle with div_start=0, busy=0 and no result_valid; result keeps its old value. op_valid in the same cycle as flush while in IDLE is ignored.
- Reset mid-operation behaves identically to flush and also clears all registers.
- All arithmetic is modulo 2^WIDTH.
- abs(0x80000000) = 0x80000000, which is valid as an unsigned magnitude.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 → result 0xFFFFFFFD (-3); REM on the same operands → 0xFFFFFFFF (-1); div_dividend=7, div_divisor=2.
- DIVU 0xFFFFFFFE / 2 → 0x7FFFFFFF; REMU 12 / 5 → 2; cmd_err=0; busy high for the whole operation.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with result_valid exactly 2 cycles after accept and div_start never asserted.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0; same 2-cycle latency, no divider activity.
- Start DIV 100/7, assert flush in the 3rd WAIT cycle → div_start low and busy low next cycle, no result_valid. A following DIVU 12/3 returns 4 correctly.
- Divider stub whose done never rises, TIMEOUT=8 → result_valid with cmd_err=1 and result=0 after 8 WAIT cycles. Then a stub pulsing div_err with done → cmd_err=1 on result_valid.
